// File: rtl/crc32_pkg.sv
// crc32_pkg: shared types and constants for the streaming CRC-32 engine.
// State encoding, IEEE 802.3 defaults and a bit-reversal helper for
// callers that work with the non-reflected form of the polynomial/result.
package crc32_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOR_OUT   = 32'hFFFFFFFF;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_step.sv
// crc32_step: combinational fold of BITS_PER_CYCLE message bits into a
// reflected CRC-32 register. bits_in[0] is the first message bit.
module crc32_step
    import crc32_pkg::*;
#(
    parameter int          BITS_PER_CYCLE = 8,
    parameter logic [31:0] POLY_REFL      = CRC32_POLY_REFL
) (
    input  logic [31:0]               crc_in,
    input  logic [BITS_PER_CYCLE-1:0] bits_in,
    output logic [31:0]               crc_next
);

    logic [31:0] c;

    // Unrolled reflected LFSR: one shift-and-conditional-XOR per message bit.
    always_comb begin
        c = crc_in;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (c[0] ^ bits_in[i]) begin
                c = (c >> 1) ^ POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        crc_next = c;
    end

endmodule

// File: rtl/crc32_stream.sv
// crc32_stream: streaming CRC-32 over multi-word frames with ready/valid on
// input and result. Each accepted word is folded BITS_PER_CYCLE bits per
// clock; the final word of a frame produces a held result until consumed.
// Optional build macro CRC32_STREAM_PARTIAL_EN adds in_bytes so the last
// word of a frame may carry fewer than DATA_W/8 valid bytes.
module crc32_stream
    import crc32_pkg::*;
#(
    parameter int          DATA_W         = 32,
    parameter int          BITS_PER_CYCLE = 8,
    parameter logic [31:0] POLY_REFL      = CRC32_POLY_REFL,
    parameter logic [31:0] INIT           = CRC32_INIT,
    parameter logic [31:0] XOR_OUT        = CRC32_XOR_OUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
`ifdef CRC32_STREAM_PARTIAL_EN
    input  logic [$clog2(DATA_W/8):0] in_bytes,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       crc_out,
    output logic              busy
);

    localparam int WORD_STEPS = DATA_W / BITS_PER_CYCLE;
    localparam int CNT_W      = $clog2(DATA_W + 1);

    state_t            state_q, state_d;
    logic [31:0]       crc_q, crc_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_start;
    logic [31:0]       crc_wide;
    logic [31:0]       fold_crc;
    logic [DATA_W-1:0] fold_sh;

    crc32_step #(
        .BITS_PER_CYCLE (BITS_PER_CYCLE),
        .POLY_REFL      (POLY_REFL)
    ) u_step (
        .crc_in   (crc_q),
        .bits_in  (sh_q[BITS_PER_CYCLE-1:0]),
        .crc_next (crc_wide)
    );

`ifdef CRC32_STREAM_PARTIAL_EN
    localparam int BYTES   = DATA_W / 8;
    localparam int BYTES_W = $clog2(BYTES) + 1;

    logic        narrow_q, narrow_d, narrow_start;
    logic [31:0] crc_bit;

    // Single-bit folder used when a short last word does not fill a whole
    // BITS_PER_CYCLE slice (only possible when BITS_PER_CYCLE exceeds a byte).
    crc32_step #(
        .BITS_PER_CYCLE (1),
        .POLY_REFL      (POLY_REFL)
    ) u_step_bit (
        .crc_in   (crc_q),
        .bits_in  (sh_q[0]),
        .crc_next (crc_bit)
    );

    // Shift length for the accepted word; a zero or full byte count means a full word.
    always_comb begin
        narrow_start = 1'b0;
        cnt_start    = CNT_W'(WORD_STEPS - 1);
        if (in_last && (in_bytes != '0) && (in_bytes < BYTES_W'(BYTES))) begin
            if (BITS_PER_CYCLE > 8) begin
                narrow_start = 1'b1;
                cnt_start    = CNT_W'(int'(in_bytes) * 8 - 1);
            end else begin
                cnt_start    = CNT_W'(int'(in_bytes) * 8 / BITS_PER_CYCLE - 1);
            end
        end
    end

    assign fold_crc = narrow_q ? crc_bit : crc_wide;
    assign fold_sh  = narrow_q ? (sh_q >> 1) : (sh_q >> BITS_PER_CYCLE);
`else
    assign cnt_start = CNT_W'(WORD_STEPS - 1);
    assign fold_crc  = crc_wide;
    assign fold_sh   = sh_q >> BITS_PER_CYCLE;
`endif

    // Next-state and datapath update: accept in IDLE, fold in SHIFT, hold in DONE.
    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        sh_d    = sh_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
`ifdef CRC32_STREAM_PARTIAL_EN
        narrow_d = narrow_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sh_d    = in_data;
                    last_d  = in_last;
                    cnt_d   = cnt_start;
                    state_d = SHIFT;
`ifdef CRC32_STREAM_PARTIAL_EN
                    narrow_d = narrow_start;
`endif
                end
            end
            SHIFT: begin
                crc_d = fold_crc;
                sh_d  = fold_sh;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = last_q ? DONE : IDLE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    crc_d   = INIT;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state and CRC register; reset drops any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            crc_q   <= INIT;
            cnt_q   <= '0;
            last_q  <= 1'b0;
`ifdef CRC32_STREAM_PARTIAL_EN
            narrow_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
`ifdef CRC32_STREAM_PARTIAL_EN
            narrow_q <= narrow_d;
`endif
        end
    end

    // Message shift register; contents are only meaningful in SHIFT.
    always_ff @(posedge clk) begin
        sh_q <= sh_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign crc_out   = (state_q == DONE) ? (crc_q ^ XOR_OUT) : 32'h0;
    assign busy      = (state_q != IDLE) || (crc_q != INIT);

endmodule

// File: tb/tb_crc32_stream.sv
// tb_crc32_stream: scoreboard bench for crc32_stream at BITS_PER_CYCLE 8, 1
// and 32. Expected CRCs come from a bytewise reference model and from known
// check values; results are popped and compared when the DUT presents them.
module tb_crc32_stream;

    localparam int          N        = 3;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [N];
    logic        in_ready  [N];
    logic [31:0] in_data   [N];
    logic        in_last   [N];
    logic        out_valid [N];
    logic        out_ready [N];
    logic [31:0] crc_out   [N];
    logic        busy      [N];
`ifdef CRC32_STREAM_PARTIAL_EN
    logic [2:0]  in_bytes  [N];
`endif

    always #5 clk = ~clk;

    crc32_stream u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_last(in_last[0]),
`ifdef CRC32_STREAM_PARTIAL_EN
        .in_bytes(in_bytes[0]),
`endif
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .crc_out(crc_out[0]), .busy(busy[0])
    );

    crc32_stream #(.BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_last(in_last[1]),
`ifdef CRC32_STREAM_PARTIAL_EN
        .in_bytes(in_bytes[1]),
`endif
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .crc_out(crc_out[1]), .busy(busy[1])
    );

    crc32_stream #(.BITS_PER_CYCLE(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .in_last(in_last[2]),
`ifdef CRC32_STREAM_PARTIAL_EN
        .in_bytes(in_bytes[2]),
`endif
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .crc_out(crc_out[2]), .busy(busy[2])
    );

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mcrc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    // Classic bytewise reflected CRC-32 update (byte XORed in, then 8 shifts).
    function automatic logic [31:0] fold_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    function automatic int bpc_of(input int k);
        return (k == 0) ? 8 : ((k == 1) ? 1 : 32);
    endfunction

    function automatic int lat_of(input int k, input int nb);
        int bpc;
        bpc = bpc_of(k);
        if (nb == 0 || nb >= 4) return 32 / bpc;
        if (bpc > 8) return nb * 8;
        return nb * 8 / bpc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input int k, input logic [31:0] d, input bit last,
                             input int nb, input bit noise);
        int n;
        int nf;
        n = 0;
        while (!in_ready[k] && n < 200) begin
            tick();
            n++;
        end
        check_eq("in_ready_idle", 32'(in_ready[k]), 32'd1);
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        in_last[k]  = last;
`ifdef CRC32_STREAM_PARTIAL_EN
        in_bytes[k] = 3'(nb);
`endif
        tick();
        in_valid[k] = 1'b0;
        nf = (last && nb != 0 && nb < 4) ? nb : 4;
        for (int i = 0; i < nf; i++) begin
            mcrc = fold_byte(mcrc, d[8*i +: 8]);
        end
        n = 0;
        while (!(last ? out_valid[k] : in_ready[k]) && n < 200) begin
            if (noise) begin
                check_eq("in_ready_busy", 32'(in_ready[k]), 32'd0);
                in_valid[k] = 1'b1;
                in_data[k]  = $urandom;
                in_last[k]  = 1'($urandom);
`ifdef CRC32_STREAM_PARTIAL_EN
                in_bytes[k] = 3'($urandom);
`endif
            end
            tick();
            n++;
        end
        in_valid[k] = 1'b0;
        check_eq("latency", n, lat_of(k, last ? nb : 0));
        if (last) begin
            exp_q.push_back(mcrc ^ 32'hFFFFFFFF);
            mcrc = CRC_INIT;
        end else begin
            check_eq("busy_mid", 32'(busy[k]), 32'(mcrc != CRC_INIT));
        end
    endtask

    task automatic wait_result(input int k, input int hold, input bit noise,
                               input logic [31:0] known, input bit has_known);
        logic [31:0] exp;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        check_eq("out_valid", 32'(out_valid[k]), 32'd1);
        check_eq("crc_model", crc_out[k], exp);
        if (has_known) check_eq("crc_known", crc_out[k], known);
        for (int i = 0; i < hold; i++) begin
            if (noise) begin
                in_valid[k] = 1'b1;
                in_data[k]  = $urandom;
                in_last[k]  = 1'($urandom);
            end
            tick();
            check_eq("hold_valid", 32'(out_valid[k]), 32'd1);
            check_eq("hold_crc", crc_out[k], exp);
            check_eq("hold_in_ready", 32'(in_ready[k]), 32'd0);
        end
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b1;
        tick();
        out_ready[k] = 1'b0;
        check_eq("out_valid_drop", 32'(out_valid[k]), 32'd0);
        check_eq("in_ready_back", 32'(in_ready[k]), 32'd1);
        check_eq("busy_clear", 32'(busy[k]), 32'd0);
        check_eq("crc_out_zero", crc_out[k], 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            in_valid[k]  = 1'b0;
            in_data[k]   = 32'h0;
            in_last[k]   = 1'b0;
            out_ready[k] = 1'b0;
`ifdef CRC32_STREAM_PARTIAL_EN
            in_bytes[k]  = 3'd0;
`endif
        end
        mcrc  = CRC_INIT;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #11;
        for (int k = 0; k < N; k++) begin
            check_eq("rst_in_ready", 32'(in_ready[k]), 32'd1);
            check_eq("rst_out_valid", 32'(out_valid[k]), 32'd0);
            check_eq("rst_crc_out", crc_out[k], 32'd0);
            check_eq("rst_busy", 32'(busy[k]), 32'd0);
        end
        rst_n = 1'b1;
        tick();

        // "1234" and four zero bytes on every folding width
        for (int k = 0; k < N; k++) begin
            send_word(k, 32'h34333231, 1'b1, 0, 1'b0);
            wait_result(k, 0, 1'b0, 32'h9BE3E0A3, 1'b1);
            send_word(k, 32'h00000000, 1'b1, 0, 1'b0);
            wait_result(k, 0, 1'b0, 32'h2144DF1C, 1'b1);
        end

        // Backpressure, then a fresh frame on the reinitialised register
        send_word(0, 32'h34333231, 1'b1, 0, 1'b0);
        wait_result(0, 10, 1'b0, 32'h9BE3E0A3, 1'b1);
        send_word(0, 32'h34333231, 1'b1, 0, 1'b0);
        wait_result(0, 0, 1'b0, 32'h9BE3E0A3, 1'b1);

        // Random traffic on in_valid/in_data while in_ready is low
        send_word(0, 32'h34333231, 1'b1, 0, 1'b1);
        wait_result(0, 6, 1'b1, 32'h9BE3E0A3, 1'b1);
        send_word(2, 32'h34333231, 1'b1, 0, 1'b1);
        wait_result(2, 3, 1'b1, 32'h9BE3E0A3, 1'b1);

        // Asynchronous reset during the second SHIFT cycle
        in_valid[0] = 1'b1;
        in_data[0]  = 32'hDEADBEEF;
        in_last[0]  = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        #1 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_in_ready", 32'(in_ready[0]), 32'd1);
        check_eq("mid_rst_out_valid", 32'(out_valid[0]), 32'd0);
        check_eq("mid_rst_crc_out", crc_out[0], 32'd0);
        check_eq("mid_rst_busy", 32'(busy[0]), 32'd0);
        #1 rst_n = 1'b1;
        mcrc = CRC_INIT;
        tick();
        send_word(0, 32'h34333231, 1'b1, 0, 1'b0);
        wait_result(0, 0, 1'b0, 32'h9BE3E0A3, 1'b1);

        // Random three-word frames against the reference model
        for (int k = 0; k < N; k++) begin
            for (int w = 0; w < 3; w++) begin
                send_word(k, $urandom, (w == 2), 0, (k == 1));
            end
            wait_result(k, 2, 1'b0, 32'h0, 1'b0);
        end

`ifdef CRC32_STREAM_PARTIAL_EN
        // "123456789" with a one-byte last word, then random short last words
        for (int k = 0; k < N; k++) begin
            send_word(k, 32'h34333231, 1'b0, 0, 1'b0);
            send_word(k, 32'h38373635, 1'b0, 0, 1'b0);
            send_word(k, 32'h00000039, 1'b1, 1, 1'b0);
            wait_result(k, 0, 1'b0, 32'hCBF43926, 1'b1);
            for (int nb = 0; nb <= 4; nb++) begin
                send_word(k, $urandom, 1'b0, 0, 1'b0);
                send_word(k, $urandom, 1'b1, nb, 1'b0);
                wait_result(k, 0, 1'b0, 32'h0, 1'b0);
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/crc32_stream.md
Name: crc32_stream

Overview:
- Streaming, parametrised CRC-32 engine; successor to the single-word CRC block.
- Accumulates a CRC over a multi-word frame and folds BITS_PER_CYCLE bits per clock, so area and timing can be traded for throughput.
- Ready/valid on input and result; sits between the ISA-extension datapath and the result writeback.

Parameters:
- DATA_W, 32, input word width in bits; multiple of 8 and of BITS_PER_CYCLE.
- BITS_PER_CYCLE, 8, message bits folded per clock; legal values 1, 2, 4, 8, 16, 32, and at most DATA_W.
- POLY_REFL, 32'hEDB88320, reflected generator polynomial (IEEE 802.3 by default).
- INIT, 32'hFFFFFFFF, register value loaded at frame start.
- XOR_OUT, 32'hFFFFFFFF, value XORed into the result.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  engine can accept a word.
- in_data  in  DATA_W  message word; byte 0 is in_data[7:0] and is processed first; bits go LSB-first.
- in_last  in  1  word is the last of the frame.
- out_valid  out  1  crc_out holds a final result.
- out_ready  in  1  consumer accepts the result.
- crc_out  out  32  final CRC: state XOR XOR_OUT, no further reflection.
- busy  out  1  a frame is in progress (state not IDLE, or the CRC register differs from INIT).

Behaviour:
- Reset (asynchronous, any time, including mid-word or while out_valid is high):
  - crc_q=INIT, FSM=IDLE.
  - in_ready=1, out_valid=0, crc_out=0, busy=0.
  - A partial frame is discarded.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_data into shift register sh_q, latch in_last, set cnt=DATA_W/BITS_PER_CYCLE-1, go to SHIFT.
  - SHIFT: in_ready=0. Each cycle crc_q=step(crc_q, sh_q[BITS_PER_CYCLE-1:0]) and sh_q>>=BITS_PER_CYCLE.
    - cnt==0 and last=0: go to IDLE.
    - cnt==0 and last=1: go to DONE.
  - DONE: out_valid=1, crc_out=crc_q^XOR_OUT, in_ready=0. On out_ready, crc_q=INIT and go to IDLE, with out_valid low the next cycle.
- step(): reflected bitwise LFSR applied per bit, i = 0..BITS_PER_CYCLE-1:
  - c = crc ^ b[i];
  - crc = (crc>>1) ^ (c[0] ? POLY_REFL : 0).
- Latency: DATA_W/BITS_PER_CYCLE SHIFT cycles per word (4 at the defaults), plus 1 IDLE accept cycle.
  - Last word: out_valid rises DATA_W/BITS_PER_CYCLE cycles after the accept edge.
- Throughput: one word per DATA_W/BITS_PER_CYCLE+1 cycles.
- A single-word frame (in_last=1 on the first word) is legal.
- crc_out is stable while out_valid=1 and out_ready=0; backpressure may last indefinitely.
- in_data and in_last are ignored whenever in_ready=0.
- With BITS_PER_CYCLE==DATA_W, SHIFT lasts exactly one cycle.

Optional Feature:
- Macro CRC32_STREAM_PARTIAL_EN.
- Defined:
  - Adds input in_bytes, width $clog2(DATA_W/8)+1, sampled with the word only when in_last=1.
  - Only bytes 0..in_bytes-1 are folded. SHIFT length becomes in_bytes*8/BITS_PER_CYCLE cycles, or in_bytes*8 cycles when BITS_PER_CYCLE>8, in which case the block folds 1 bit per cycle for that word.
  - in_bytes=0 on a last word is treated as DATA_W/8.
- Undefined: no port; every word is full.

Decomposition:
- Package crc32_pkg:
  - state enum {IDLE, SHIFT, DONE};
  - constants CRC32_POLY_REFL, CRC32_INIT, CRC32_XOR_OUT;
  - function reflect32 for the non-reflected users.
- Sub-module crc32_step: purely combinational, parameter BITS_PER_CYCLE. Inputs crc_in[31:0] and bits_in; output crc_next[31:0]. Unit-testable in isolation.

Test Plan:
- Defaults, one word 32'h34333231 ("1234") with in_last=1 -> out_valid 4 cycles after accept, crc_out=32'h9BE3E0A3.
- One word 32'h00000000 with in_last=1 -> crc_out=32'h2144DF1C. Repeat with BITS_PER_CYCLE=1 and =32: same value, after 32 and 1 SHIFT cycles respectively.
- With CRC32_STREAM_PARTIAL_EN, "123456789" sent as 32'h34333231, 32'h38373635, then 32'h00000039 with in_last=1, in_bytes=1 -> crc_out=32'hCBF43926.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid and crc_out stable, in_ready=0. Then pulse out_ready -> IDLE, and the next "1234" frame again gives 32'h9BE3E0A3 (register was reinitialised).
- Assert rst_n low during the 2nd SHIFT cycle of a frame -> all outputs at reset values immediately; a following "1234" frame gives 32'h9BE3E0A3.
- Drive in_valid with random data while in_ready=0 -> the data is ignored and the result is unchanged versus the clean run.
